moore_run_detector: RTL and testbench
=====================================

# moore_run_detector

Parametrised Moore-style run-length detector for serial bit streams. It is the configurable successor to the fixed three-state "two-or-more consecutive ones" detector. It generalises the required run length, adds selectable polarity (runs of 1s or 0s), a sample-valid qualifier and a synchronous clear, and exposes run-length and detection-count status. It sits after a serial deserialiser or line decoder and feeds event or interrupt logic.

## Interface
- RUN_LEN, 2, number of consecutive matching samples needed to enter detect; legal range 1 .. 2^RL_W-1.
- RL_W, 8, width of the run-length counter.
- CNT_W, 16, width of the detection-event counter.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value.
- clear  in  1  synchronous clear; same effect as reset on the next edge; has priority over in_valid.
- in_valid  in  1  qualifies in_bit; when low, all state holds.
- in_bit  in  1  serial data sample.
- polarity  in  1  0 = detect runs of 1s; 1 = detect runs of 0s; evaluated per valid sample.
- out_bit  out  1  Moore output; high while the state is S_DET.
- det_pulse  out  1  high for exactly the first cycle spent in S_DET after entry.
- run_len  out  RL_W  current run length; saturates at 2^RL_W-1.
- det_count  out  CNT_W  number of entries into S_DET; wraps modulo 2^CNT_W.
- det_overflow  out  1  sticky; set when det_count wraps from all-ones to 0.

## Operation
- match = in_valid & (in_bit != polarity).
- States:
  - S_IDLE: run_len = 0.
  - S_RUN: 0 < run_len < RUN_LEN.
  - S_DET: run_len >= RUN_LEN.
  - Unused encodings return to S_IDLE.
- On a valid matching sample:
  - run_len_n = min(run_len+1, 2^RL_W-1).
  - Next state is S_DET if run_len_n >= RUN_LEN, otherwise S_RUN.
- On a valid non-matching sample: next state S_IDLE, run_len_n = 0.
- When in_valid = 0: state, run_len and all outputs hold. det_pulse drops to 0 after its one cycle.
- With RUN_LEN = 1, the FSM goes S_IDLE to S_DET directly; S_RUN is never entered.
- Entering S_DET from S_IDLE or S_RUN:
  - det_pulse = 1 for that cycle.
  - det_count increments.
  - If det_count was all-ones it wraps to 0 and det_overflow sets.
- Staying in S_DET does not re-pulse and does not count.
- A polarity change mid-run applies to the next valid sample; the run continues only if that sample matches the new polarity.
- clear = 1 at an edge: S_IDLE, run_len = 0, det_count = 0, det_overflow = 0, det_pulse = 0, regardless of in_valid.

## Timing
- All outputs are registered, decoded from state and counters only, with no combinational path from inputs.
- Reset values: state S_IDLE, out_bit 0, det_pulse 0, run_len 0, det_count 0, det_overflow 0.
- Latency: out_bit and det_pulse rise in the cycle after the edge that samples the RUN_LEN-th consecutive match.
- out_bit falls in the cycle after the edge that samples the first valid mismatch.
- run_len reflects all samples up to and including the previous edge.
- Reset asserted mid-run clears immediately (asynchronously). The first sample counted after release is the one at the first edge with reset low.
- Run-length saturation does not affect state: the FSM stays in S_DET while matches continue.

## Test plan
- RUN_LEN=2, polarity=0, in_valid=1, in_bit 0,1,1,1,0 -> out_bit 0,0,1,1,0 (one cycle after each sample), det_pulse high once, det_count=1.
- RUN_LEN=3, polarity=1, in_bit 0,0,1,0,0,0 -> out_bit high only after the 6th sample, det_count=1, run_len=3.
- RUN_LEN=2, in_bit 1,(in_valid=0 ×3),1 -> no reset of the run; out_bit rises after the second valid 1; run_len=2.
- RUN_LEN=1, CNT_W=2, alternating 1,0 for 8 valid samples -> 4 det_pulses, det_count wraps 3 to 0 on the 4th, det_overflow=1.
- RL_W=2, RUN_LEN=3, six consecutive 1s -> run_len saturates at 3, out_bit stays 1, det_count=1.
- Mid-S_DET clear=1 together with in_valid=1, in_bit=1 -> next cycle all outputs 0. Async reset pulse between edges -> outputs 0 immediately.

Source files
------------

// File: rtl/moore_run_detector_if.sv
// moore_run_detector_if: sample stream in, run/detect status out.
interface moore_run_detector_if #(
    parameter int RL_W  = 8,
    parameter int CNT_W = 16
);
    logic             clear;
    logic             in_valid;
    logic             in_bit;
    logic             polarity;
    logic             out_bit;
    logic             det_pulse;
    logic [RL_W-1:0]  run_len;
    logic [CNT_W-1:0] det_count;
    logic             det_overflow;
    modport master (
        output clear, in_valid, in_bit, polarity,
        input  out_bit, det_pulse, run_len, det_count, det_overflow
    );
    modport slave (
        input  clear, in_valid, in_bit, polarity,
        output out_bit, det_pulse, run_len, det_count, det_overflow
    );
endinterface

// File: rtl/moore_run_detector.sv
// moore_run_detector: Moore FSM flagging runs of RUN_LEN matching samples,
// with saturating run length, detection-event counter and sticky overflow.
module moore_run_detector #(
    parameter int RUN_LEN = 2,
    parameter int RL_W    = 8,
    parameter int CNT_W   = 16
) (
    input logic                  clk,
    input logic                  reset,
    moore_run_detector_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DET = 2'd2} state_t;
    localparam logic [RL_W-1:0] RL_MAX = '1;
    localparam logic [RL_W-1:0] RL_THR = RL_W'(RUN_LEN);
    state_t           r_state, w_state_n;
    logic [RL_W-1:0]  r_run, w_run_n, w_run_inc;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic             r_pulse, w_pulse_n, r_ovf, w_ovf_n, w_match, w_enter;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_run   <= '0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_run   <= w_run_n;
            r_cnt   <= w_cnt_n;
            r_pulse <= w_pulse_n;
            r_ovf   <= w_ovf_n;
        end
    end
    // Illegal state encodings fall back to S_IDLE even while samples are invalid.
    always_comb begin
        w_match   = bus.in_valid & (bus.in_bit != bus.polarity);
        w_run_inc = (r_run == RL_MAX) ? r_run : r_run + 1'b1;
        w_state_n = bus.clear     ? S_IDLE :
                    !bus.in_valid ? ((r_state == S_RUN || r_state == S_DET) ? r_state : S_IDLE) :
                    !w_match      ? S_IDLE :
                    (w_run_inc >= RL_THR) ? S_DET : S_RUN;
        w_run_n   = (bus.clear || (bus.in_valid && !w_match)) ? '0 : w_match ? w_run_inc : r_run;
        w_enter   = (w_state_n == S_DET) && (r_state != S_DET);
        w_pulse_n = w_enter;
        w_cnt_n   = bus.clear ? '0 : w_enter ? r_cnt + 1'b1 : r_cnt;
        w_ovf_n   = bus.clear ? 1'b0 : r_ovf | (w_enter & (&r_cnt));
    end
    assign bus.out_bit      = (r_state == S_DET);
    assign bus.det_pulse    = r_pulse;
    assign bus.run_len      = r_run;
    assign bus.det_count    = r_cnt;
    assign bus.det_overflow = r_ovf;
endmodule

// File: tb/tb_moore_run_detector.sv
// tb_moore_run_detector: four configurations share one stimulus stream and are
// checked every cycle against a run-counting reference model.
module tb_moore_run_detector;
    logic clk = 1'b0, reset = 1'b1;
    logic clear = 1'b0, in_valid = 1'b0, in_bit = 1'b0, polarity = 1'b0;
    int   n_chk = 0, n_fail = 0, pulses;
    localparam int RL[4]   = '{2, 3, 1, 3};
    localparam int RMAX[4] = '{255, 255, 255, 3};
    localparam int CMOD[4] = '{65536, 65536, 4, 65536};
    moore_run_detector_if #(.RL_W(8), .CNT_W(16)) b0 ();
    moore_run_detector_if #(.RL_W(8), .CNT_W(16)) b1 ();
    moore_run_detector_if #(.RL_W(8), .CNT_W(2))  b2 ();
    moore_run_detector_if #(.RL_W(2), .CNT_W(16)) b3 ();
    moore_run_detector #(.RUN_LEN(2), .RL_W(8), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
    moore_run_detector #(.RUN_LEN(3), .RL_W(8), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
    moore_run_detector #(.RUN_LEN(1), .RL_W(8), .CNT_W(2))  u2 (.clk(clk), .reset(reset), .bus(b2.slave));
    moore_run_detector #(.RUN_LEN(3), .RL_W(2), .CNT_W(16)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));
    assign b0.clear = clear; assign b0.in_valid = in_valid; assign b0.in_bit = in_bit; assign b0.polarity = polarity;
    assign b1.clear = clear; assign b1.in_valid = in_valid; assign b1.in_bit = in_bit; assign b1.polarity = polarity;
    assign b2.clear = clear; assign b2.in_valid = in_valid; assign b2.in_bit = in_bit; assign b2.polarity = polarity;
    assign b3.clear = clear; assign b3.in_valid = in_valid; assign b3.in_bit = in_bit; assign b3.polarity = polarity;
    logic a_out[4], a_pul[4], a_ovf[4];
    int   a_run[4], a_cnt[4];
    always_comb begin
        a_out[0] = b0.out_bit; a_pul[0] = b0.det_pulse; a_ovf[0] = b0.det_overflow;
        a_out[1] = b1.out_bit; a_pul[1] = b1.det_pulse; a_ovf[1] = b1.det_overflow;
        a_out[2] = b2.out_bit; a_pul[2] = b2.det_pulse; a_ovf[2] = b2.det_overflow;
        a_out[3] = b3.out_bit; a_pul[3] = b3.det_pulse; a_ovf[3] = b3.det_overflow;
        a_run[0] = int'(b0.run_len); a_cnt[0] = int'(b0.det_count);
        a_run[1] = int'(b1.run_len); a_cnt[1] = int'(b1.det_count);
        a_run[2] = int'(b2.run_len); a_cnt[2] = int'(b2.det_count);
        a_run[3] = int'(b3.run_len); a_cnt[3] = int'(b3.det_count);
    end
    always #5 clk = ~clk;
    // Reference: unbounded run of matches; detect means run >= RUN_LEN.
    int m_run[4], m_cnt[4];
    bit m_pul[4], m_ovf[4];
    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 4; k++) begin
            int nr, nc;
            bit np, no;
            nr = m_run[k]; nc = m_cnt[k]; np = 1'b0; no = m_ovf[k];
            if (reset || clear) begin
                nr = 0; nc = 0; no = 1'b0;
            end else if (in_valid) begin
                nr = (in_bit != polarity) ? m_run[k] + 1 : 0;
                if (m_run[k] < RL[k] && nr >= RL[k]) begin
                    np = 1'b1;
                    nc = (m_cnt[k] + 1) % CMOD[k];
                    if (nc == 0) no = 1'b1;
                end
            end
            m_run[k] <= nr; m_cnt[k] <= nc; m_pul[k] <= np; m_ovf[k] <= no;
        end
    end
    task automatic chk(string name, int k, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk("out_bit", k, int'(a_out[k]), int'(m_run[k] >= RL[k]));
            chk("det_pulse", k, int'(a_pul[k]), int'(m_pul[k]));
            chk("run_len", k, a_run[k], (m_run[k] > RMAX[k]) ? RMAX[k] : m_run[k]);
            chk("det_count", k, a_cnt[k], m_cnt[k]);
            chk("det_overflow", k, int'(a_ovf[k]), int'(m_ovf[k]));
        end
    end
    task automatic put(input logic c, input logic v, input logic b, input logic p);
        clear = c; in_valid = v; in_bit = b; polarity = p;
        @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        #3;
        chk("rst_out", 0, int'(a_out[0]), 0);
        chk("rst_run", 0, a_run[0], 0);
        chk("rst_cnt", 0, a_cnt[0], 0);
        #9 reset = 1'b0;
        // RUN_LEN=2, runs of ones: 0,1,1,1,0 -> out 0,0,1,1,0
        put(0, 1, 0, 0); chk("t1_out", 0, int'(a_out[0]), 0);
        put(0, 1, 1, 0); chk("t1_out", 0, int'(a_out[0]), 0);
        put(0, 1, 1, 0); chk("t1_out", 0, int'(a_out[0]), 1); chk("t1_pulse", 0, int'(a_pul[0]), 1);
        put(0, 1, 1, 0); chk("t1_out", 0, int'(a_out[0]), 1); chk("t1_pulse", 0, int'(a_pul[0]), 0);
        put(0, 1, 0, 0); chk("t1_out", 0, int'(a_out[0]), 0); chk("t1_cnt", 0, a_cnt[0], 1);
        put(1, 1, 1, 0);
        // RUN_LEN=3, runs of zeros: 0,0,1,0,0,0
        put(0, 1, 0, 1); put(0, 1, 0, 1); put(0, 1, 1, 1); put(0, 1, 0, 1); put(0, 1, 0, 1);
        chk("t2_out5", 1, int'(a_out[1]), 0);
        put(0, 1, 0, 1);
        chk("t2_out6", 1, int'(a_out[1]), 1); chk("t2_cnt", 1, a_cnt[1], 1); chk("t2_run", 1, a_run[1], 3);
        put(1, 0, 0, 0);
        // invalid samples hold the run
        put(0, 1, 1, 0); put(0, 0, 0, 0); put(0, 0, 0, 0); put(0, 0, 1, 0);
        chk("t3_hold_run", 0, a_run[0], 1); chk("t3_hold_out", 0, int'(a_out[0]), 0);
        put(0, 1, 1, 0);
        chk("t3_out", 0, int'(a_out[0]), 1); chk("t3_run", 0, a_run[0], 2);
        put(1, 0, 0, 0);
        // RUN_LEN=1, CNT_W=2: four entries wrap the counter
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            put(0, 1, ~i[0], 0);
            if (a_pul[2]) pulses++;
        end
        chk("t4_pulses", 2, pulses, 4); chk("t4_cnt", 2, a_cnt[2], 0); chk("t4_ovf", 2, int'(a_ovf[2]), 1);
        put(1, 0, 0, 0);
        chk("clr_ovf", 2, int'(a_ovf[2]), 0);
        // RL_W=2 saturation while staying in detect
        for (int i = 0; i < 6; i++) put(0, 1, 1, 0);
        chk("t5_run", 3, a_run[3], 3); chk("t5_out", 3, int'(a_out[3]), 1); chk("t5_cnt", 3, a_cnt[3], 1);
        chk("t5_run_wide", 0, a_run[0], 6);
        // clear beats a valid matching sample
        put(1, 1, 1, 0);
        chk("t6_out", 0, int'(a_out[0]), 0); chk("t6_run", 0, a_run[0], 0); chk("t6_cnt", 0, a_cnt[0], 0);
        chk("t6_out3", 3, int'(a_out[3]), 0);
        put(0, 1, 1, 0); put(0, 1, 1, 0);
        chk("t7_pre", 0, int'(a_out[0]), 1);
        #2 reset = 1'b1;
        #1;
        chk("t7_async_out", 0, int'(a_out[0]), 0); chk("t7_async_run", 0, a_run[0], 2 - 2);
        chk("t7_async_cnt", 0, a_cnt[0], 0);
        reset = 1'b0;
        @(posedge clk); #1;
        // mixed tail: polarity switches and gaps
        put(0, 1, 1, 0); put(0, 1, 0, 1); put(0, 0, 1, 1); put(0, 1, 0, 1);
        put(0, 1, 0, 1); put(0, 1, 1, 0); put(0, 1, 1, 0); put(0, 0, 0, 0);
        put(0, 1, 1, 0); put(0, 1, 0, 0); put(0, 1, 0, 1); put(0, 1, 0, 1);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
